// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state encoding and frame constants for boot_loader
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_FIN    = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } boot_state_t;

  localparam logic [7:0] BOOT_MAGIC     = 8'hA5;
  localparam int         BOOT_LEN_BYTES = 2;
  localparam logic [3:0] BOOT_WORD_ENB  = 4'hF;

  // The loader takes bytes only while a frame can still be in progress.
  function automatic logic accepts_bytes(input boot_state_t st);
    return (st == ST_IDLE) || (st == ST_LEN_LO) || (st == ST_LEN_HI) ||
           (st == ST_DATA) || (st == ST_CSUM);
  endfunction

endpackage

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - byte-stream program loader for instruction memory (option: BOOT_CHECKSUM_EN)
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        boot_req,
  output logic [3:0]  mem_w_enb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] CAP_WORDS = 32'd1 << (ADDR_BITS - 2);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t AFTER_DATA = ST_CSUM;
`else
  localparam boot_state_t AFTER_DATA = ST_FIN;
`endif

  boot_state_t state;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] shift_reg;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  logic        take;
  logic [15:0] len_new;

  // Length high byte arrives on the wire while the low byte sits in n_words.
  assign len_new  = {rx_data, n_words[7:0]};
  assign rx_ready = accepts_bytes(state);
  assign take     = rx_valid && rx_ready;

  // Frame parser, word assembler and registered memory/core control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      n_words    <= 16'd0;
      word_idx   <= 16'd0;
      byte_cnt   <= 2'd0;
      shift_reg  <= 24'd0;
`ifdef BOOT_CHECKSUM_EN
      sum        <= 8'd0;
`endif
      mem_w_enb  <= 4'h0;
      mem_addr   <= 32'd0;
      mem_w_data <= 32'd0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse; address and data hold.
      mem_w_enb <= 4'h0;
      case (state)
        ST_IDLE: begin
          if (take && rx_data == BOOT_MAGIC) state <= ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (take) begin
            n_words[7:0] <= rx_data;
            state        <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (take) begin
            n_words <= len_new;
            if (32'(len_new) > CAP_WORDS) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else if (len_new == 16'd0) begin
              state <= AFTER_DATA;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (take) begin
            shift_reg <= {rx_data, shift_reg[23:8]};
            byte_cnt  <= byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            sum       <= sum + rx_data;
`endif
            if (byte_cnt == 2'd3) begin
              mem_w_enb  <= BOOT_WORD_ENB;
              mem_addr   <= {14'd0, word_idx, 2'b00};
              mem_w_data <= {rx_data, shift_reg};
              word_idx   <= word_idx + 16'd1;
              if (word_idx + 16'd1 == n_words) state <= AFTER_DATA;
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CSUM: begin
          if (take) begin
            if (rx_data == sum) begin
              state <= ST_FIN;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        ST_FIN: begin
          state    <= ST_DONE;
          done     <= 1'b1;
          core_rst <= 1'b0;
        end
        ST_DONE, ST_ERROR: begin
          if (boot_req) begin
            state    <= ST_IDLE;
            core_rst <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
            sum      <= 8'd0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - randomized self-checking bench for boot_loader (honours BOOT_CHECKSUM_EN)
module tb_boot_loader;

  localparam int ADDR_BITS = 10;
  localparam int CAP = 1 << (ADDR_BITS - 2);

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        boot_req;
  logic [3:0]  mem_w_enb;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic        core_rst;
  logic        done;
  logic        error;

  boot_loader #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .boot_req(boot_req), .mem_w_enb(mem_w_enb), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .core_rst(core_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed write pulses, one entry per cycle the strobe is non-zero.
  logic [31:0] seen_addr[$];
  logic [31:0] seen_data[$];
  logic [3:0]  seen_enb[$];
  int          seen_cyc[$];
  int          acc_cyc[$];

  always @(negedge clk) begin
    if (rst === 1'b0 && mem_w_enb !== 4'h0) begin
      seen_addr.push_back(mem_addr);
      seen_data.push_back(mem_w_data);
      seen_enb.push_back(mem_w_enb);
      seen_cyc.push_back(cyc);
    end
  end

  // Reference model outputs.
  logic [7:0]  frm[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_idx[$];
  bit          exp_err;
  int          exp_used;

  // Parse a frame from the protocol rules: what memory should hold and how it ends.
  task automatic model_frame();
    int i;
    int n;
    int s;
    i = 0;
    s = 0;
    exp_addr.delete(); exp_data.delete(); exp_idx.delete();
    while (i < frm.size() && frm[i] != 8'hA5) i++;
    i++;
    n = int'(frm[i]) + 256 * int'(frm[i+1]);
    i += 2;
    if (n > CAP) begin
      exp_err = 1'b1;
      exp_used = i;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(32'(4 * w));
      exp_data.push_back({frm[i+3], frm[i+2], frm[i+1], frm[i]});
      exp_idx.push_back(i + 3);
      for (int b = 0; b < 4; b++) s += int'(frm[i+b]);
      i += 4;
    end
`ifdef BOOT_CHECKSUM_EN
    exp_err = (int'(frm[i]) != (s % 256));
    i++;
`else
    exp_err = 1'b0;
`endif
    exp_used = i;
  endtask

  task automatic append_sum(input int skip, input int delta);
    int s;
    s = delta;
    for (int i = skip; i < frm.size(); i++) s += int'(frm[i]);
    frm.push_back(8'(s));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int gap;
    int t;
    gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (rx_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL rx_ready_timeout: rx_ready=%b required 1 for byte %02h", rx_ready, b);
    end
    @(negedge clk);
    acc_cyc.push_back(cyc);
  endtask

  task automatic pulse_boot_req(input string name);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    checks++;
    if ({done, error, core_rst, rx_ready, mem_w_enb} !== {1'b0, 1'b0, 1'b1, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL %s_boot_req: done/error/core_rst/rx_ready/enb=%b%b%b%b/%h required 0011/0",
               name, done, error, core_rst, rx_ready, mem_w_enb);
    end
  endtask

  // Drive frm through the loader, then check writes, latency and the final state.
  task automatic test_frame(input string name, input int gapmax);
    seen_addr.delete(); seen_data.delete(); seen_enb.delete(); seen_cyc.delete(); acc_cyc.delete();
    model_frame();
    for (int i = 0; i < exp_used; i++) send_byte(frm[i], gapmax);
    rx_valid = 1'b0;
    if (!exp_err) begin
      checks++;
      if ({done, rx_ready, core_rst} !== 3'b001) begin
        errors++;
        $display("FAIL %s_fin: done/rx_ready/core_rst=%b%b%b required 001", name, done, rx_ready, core_rst);
      end
      @(negedge clk);
      checks++;
      if ({done, core_rst, error} !== 3'b100) begin
        errors++;
        $display("FAIL %s_done: done/core_rst/error=%b%b%b required 100", name, done, core_rst, error);
      end
    end else begin
      checks++;
      if ({error, core_rst, rx_ready, done} !== 4'b1100) begin
        errors++;
        $display("FAIL %s_error: error/core_rst/rx_ready/done=%b%b%b%b required 1100", name, error, core_rst, rx_ready, done);
      end
      @(negedge clk);
      checks++;
      if ({error, done} !== 2'b10) begin
        errors++;
        $display("FAIL %s_error_hold: error/done=%b%b required 10", name, error, done);
      end
    end
    checks++;
    if (seen_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required %0d", name, seen_addr.size(), exp_addr.size());
    end
    for (int w = 0; w < exp_addr.size() && w < seen_addr.size(); w++) begin
      checks++;
      if (seen_addr[w] !== exp_addr[w] || seen_data[w] !== exp_data[w] || seen_enb[w] !== 4'hF ||
          seen_cyc[w] !== acc_cyc[exp_idx[w]]) begin
        errors++;
        $display("FAIL %s_write%0d: addr=%h data=%h enb=%h cyc=%0d required addr=%h data=%h enb=f cyc=%0d",
                 name, w, seen_addr[w], seen_data[w], seen_enb[w], seen_cyc[w],
                 exp_addr[w], exp_data[w], acc_cyc[exp_idx[w]]);
      end
    end
    pulse_boot_req(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; boot_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({core_rst, done, error, mem_w_enb, rx_ready} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b1} ||
        mem_addr !== 32'd0 || mem_w_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: core_rst=%b done=%b error=%b enb=%h ready=%b addr=%h data=%h required 1 0 0 0 1 0 0",
               core_rst, done, error, mem_w_enb, rx_ready, mem_addr, mem_w_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_words();
    frm = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef BOOT_CHECKSUM_EN
    append_sum(3, 0);
`endif
    test_frame("two_words", 0);
  endtask

  task automatic test_leading_garbage();
    frm = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    append_sum(6, 0);
`endif
    test_frame("garbage", 2);
  endtask

  task automatic test_zero_len();
    frm = {8'hA5, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    frm.push_back(8'h00);
`endif
    test_frame("zero_len", 1);
  endtask

  task automatic test_oversize();
    frm = {8'hA5, 8'h01, 8'h01};
    test_frame("oversize", 1);
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_bad_checksum();
    frm = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    append_sum(3, 1);
    test_frame("bad_csum", 1);
  endtask
`endif

  task automatic test_random_frames();
    int n;
    int g;
    for (int k = 0; k < 10; k++) begin
      frm.delete();
      g = int'($urandom_range(0, 3));
      for (int i = 0; i < g; i++) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        frm.push_back(b == 8'hA5 ? 8'h00 : b);
      end
      if (k == 7) n = CAP + 1 + int'($urandom_range(0, 65535 - CAP - 1));
      else if (k == 3) n = 0;
      else n = int'($urandom_range(1, 6));
      frm.push_back(8'hA5);
      frm.push_back(8'(n));
      frm.push_back(8'(n >> 8));
      if (n <= CAP) begin
        for (int i = 0; i < 4 * n; i++) frm.push_back(8'($urandom_range(0, 255)));
`ifdef BOOT_CHECKSUM_EN
        append_sum(g + 3, (k == 5) ? int'($urandom_range(1, 255)) : 0);
`endif
      end
      test_frame("random", 3);
    end
  endtask

  task automatic test_back_to_back();
    frm = {8'hA5, 8'(CAP), 8'(CAP >> 8)};
    for (int i = 0; i < 4 * CAP; i++) frm.push_back(8'($urandom_range(0, 255)));
`ifdef BOOT_CHECKSUM_EN
    append_sum(3, 0);
`endif
    test_frame("full_b2b", 0);
  endtask

  task automatic test_boot_req_ignored();
    frm = {8'hA5, 8'h01, 8'h00, 8'hC3, 8'hB2, 8'hA1, 8'h90};
`ifdef BOOT_CHECKSUM_EN
    append_sum(3, 0);
`endif
    seen_addr.delete(); seen_data.delete(); seen_enb.delete(); seen_cyc.delete(); acc_cyc.delete();
    send_byte(frm[0], 0);
    send_byte(frm[1], 0);
    rx_valid = 1'b0;
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    for (int i = 2; i < frm.size(); i++) send_byte(frm[i], 0);
    rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || seen_data.size() != 1) begin
      errors++;
      $display("FAIL boot_req_ignored: done=%b writes=%0d required done=1 writes=1", done, seen_data.size());
    end else begin
      checks++;
      if (seen_data[0] !== 32'h90A1B2C3 || seen_addr[0] !== 32'd0) begin
        errors++;
        $display("FAIL boot_req_ignored_data: addr=%h data=%h required 0 90a1b2c3", seen_addr[0], seen_data[0]);
      end
    end
    pulse_boot_req("boot_req_ignored");
  endtask

  task automatic test_mid_reset();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({core_rst, done, error, mem_w_enb, rx_ready} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b1} ||
        mem_addr !== 32'd0 || mem_w_data !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_values: core_rst=%b done=%b error=%b enb=%h ready=%b addr=%h data=%h",
               core_rst, done, error, mem_w_enb, rx_ready, mem_addr, mem_w_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    rx_valid = 1'b0;
    checks++;
    if (mem_w_enb !== 4'hF || mem_w_data !== 32'h44332211) begin
      errors++;
      $display("FAIL pulse_before_reset: enb=%h data=%h required f 44332211", mem_w_enb, mem_w_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_w_enb !== 4'h0 || core_rst !== 1'b1 || mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL pulse_cancel: enb=%h core_rst=%b addr=%h required 0 1 0", mem_w_enb, core_rst, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frm = {8'hA5, 8'h02, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
`ifdef BOOT_CHECKSUM_EN
    append_sum(3, 0);
`endif
    test_frame("after_reset", 1);
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_leading_garbage();
    test_zero_len();
    test_oversize();
`ifdef BOOT_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_boot_req_ignored();
    test_random_frames();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
